// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register (usr) and its sequencer.
//   MODE_*   : usr mode encodings (hold, parallel load, shift right, shift left)
//   seq_state_t : sequencer FSM state encoding
//   shift_mode  : maps a direction bit onto the matching shift mode
package usr_pkg;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_LOAD = 2'b01;
  localparam logic [1:0] MODE_SHR  = 2'b10;
  localparam logic [1:0] MODE_SHL  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_t;

  // dir = 0 -> shift right, dir = 1 -> shift left
  function automatic logic [1:0] shift_mode(input logic dir);
    return dir ? MODE_SHL : MODE_SHR;
  endfunction

endpackage

// File: rtl/usr_seq_ctrl_if.sv
// Job/usr-control bundle between a job requester and usr_seq_ctrl.
//   start, dir, count, din : job request (requester -> sequencer)
//   ready                  : sequencer can accept a job (IDLE)
//   mode, data             : drive usr.mode / usr.data
//   busy, done             : job status; done is a one-cycle pulse
// Handshake: a job is accepted on a rising clock edge where start=1 and
// ready=1; dir/count/din are sampled on that same edge only. start while
// ready=0 is dropped, never queued.
// Modports: master = job requester, slave = sequencer.
interface usr_seq_ctrl_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
);
  logic             start;
  logic             ready;
  logic             dir;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] din;
  logic [1:0]       mode;
  logic [WIDTH-1:0] data;
  logic             busy;
  logic             done;

  modport master (
    output start, dir, count, din,
    input  ready, mode, data, busy, done
  );

  modport slave (
    input  start, dir, count, din,
    output ready, mode, data, busy, done
  );
endinterface

// File: rtl/usr_shift_cnt.sv
// Loadable down-counter tracking the remaining shifts of a job.
//   clk, rst    : clock, synchronous active-high reset (count -> 0)
//   i_load      : load i_load_val (priority over decrement)
//   i_load_val  : value to load
//   i_dec       : decrement by one; saturates at zero
//   o_cnt       : current count
//   o_zero      : count == 0
module usr_shift_cnt #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_cnt  = r_cnt;
  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/usr_seq_ctrl.sv
// Sequencer for the universal shift register: takes one job (word, direction,
// shift count) and drives usr mode/data as load, N shifts, hold, then pulses
// done.
//   clk, rst    : clock, synchronous active-high reset (aborts any job)
//   bus         : usr_seq_ctrl_if slave (start/ready/dir/count/din in,
//                 mode/data/busy/done out)
//   o_dbg_state : current FSM state, for observation only
// mode/busy/done are registered copies of the state decode, so they trail the
// FSM state by one cycle; usr therefore captures the word two edges after
// accept and done appears count+2 edges after accept.
module usr_seq_ctrl
  import usr_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic            clk,
  input  logic            rst,
  usr_seq_ctrl_if.slave   bus,
  output seq_state_t      o_dbg_state
);

  seq_state_t       r_state;
  seq_state_t       w_next;

  logic [1:0]       r_mode;
  logic [WIDTH-1:0] r_data;
  logic             r_busy;
  logic             r_done;
  logic             r_dir;

  logic [1:0]       w_mode;
  logic             w_busy;
  logic             w_done;
  logic             w_dec;
  logic             w_accept;
  logic [CNT_W-1:0] w_count_clamped;
  logic [CNT_W-1:0] w_cnt;
  logic             w_cnt_zero;

  assign w_accept = (r_state == ST_IDLE) && bus.start;

  // More shifts than bits would only repeat the all-zero result.
  assign w_count_clamped = (bus.count > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : bus.count;

  usr_shift_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_accept),
    .i_load_val (w_count_clamped),
    .i_dec      (w_dec),
    .o_cnt      (w_cnt),
    .o_zero     (w_cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    w_mode = MODE_HOLD;
    w_busy = 1'b0;
    w_done = 1'b0;
    w_dec  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_next = ST_LOAD;
        end
      end
      ST_LOAD: begin
        w_mode = MODE_LOAD;
        w_busy = 1'b1;
        w_next = w_cnt_zero ? ST_DONE : ST_SHIFT;
      end
      ST_SHIFT: begin
        w_mode = shift_mode(r_dir);
        w_busy = 1'b1;
        w_dec  = 1'b1;
        // Counter holds the shifts still to issue, including this one.
        if (w_cnt == CNT_W'(1)) begin
          w_next = ST_DONE;
        end
      end
      ST_DONE: begin
        w_busy = 1'b1;
        w_done = 1'b1;
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode <= MODE_HOLD;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_data <= '0;
      r_dir  <= 1'b0;
    end else begin
      r_mode <= w_mode;
      r_busy <= w_busy;
      r_done <= w_done;
      if (w_accept) begin
        r_data <= bus.din;
        r_dir  <= bus.dir;
      end
    end
  end

  assign bus.ready   = (r_state == ST_IDLE);
  assign bus.mode    = r_mode;
  assign bus.data    = r_data;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_usr_seq_ctrl.sv
// Bench for usr_seq_ctrl driving a behavioural usr register.
module tb_usr_seq_ctrl;
  import usr_pkg::*;

  localparam int WIDTH = 4;
  localparam int CNT_W = 3;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  seq_state_t dbg_state;

  always #5 clk = ~clk;

  usr_seq_ctrl_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) sif ();

  usr_seq_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (sif.slave),
    .o_dbg_state (dbg_state)
  );

  // Behavioural usr: load, or shift with a zero shifted in.
  logic [WIDTH-1:0] usr_y;
  always @(posedge clk) begin
    if (rst) usr_y <= '0;
    else begin
      case (sif.mode)
        MODE_LOAD: usr_y <= sif.data;
        MODE_SHR:  usr_y <= usr_y >> 1;
        MODE_SHL:  usr_y <= usr_y << 1;
        default:   usr_y <= usr_y;
      endcase
    end
  end

  int done_seen = 0;
  always @(posedge clk) if (sif.done) done_seen <= done_seen + 1;

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [WIDTH-1:0] exp_q[$];

  // ---------------- reference model ----------------
  function automatic int clamp(input int count);
    return (count > WIDTH) ? WIDTH : count;
  endfunction

  function automatic logic [WIDTH-1:0] final_word(input logic [WIDTH-1:0] din,
                                                  input logic dir, input int c);
    logic [WIDTH-1:0] t;
    t = din;
    t = dir ? (t << c) : (t >> c);
    return t;
  endfunction

  // Expected {mode, busy, done, ready} j edges after the accepting edge.
  function automatic logic [4:0] exp_sig(input int j, input int c, input logic dir);
    logic [1:0] m;
    logic b, d, r;
    if (j == 1) m = MODE_LOAD;
    else if (j >= 2 && j <= c + 1) m = dir ? MODE_SHL : MODE_SHR;
    else m = MODE_HOLD;
    b = (j >= 1) && (j <= c + 2);
    d = (j == c + 2);
    r = (j >= c + 2);
    return {m, b, d, r};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    sif.start = 1'b0; sif.dir = 1'b0; sif.count = '0; sif.din = '0;
    rst = 1'b1;
    step(); step();
    checks++;
    if ({sif.mode, sif.busy, sif.done, sif.ready} !== 5'b00_0_0_1) begin
      failures++;
      $display("FAIL reset_outputs: got %b expected %b",
               {sif.mode, sif.busy, sif.done, sif.ready}, 5'b00_0_0_1);
    end
    checks++;
    if (sif.data !== '0) begin
      failures++;
      $display("FAIL reset_data: got %b expected %b", sif.data, 4'b0000);
    end
    checks++;
    if (dbg_state !== ST_IDLE) begin
      failures++;
      $display("FAIL reset_state: got %0d expected %0d", dbg_state, ST_IDLE);
    end
    rst = 1'b0;
    step();
  endtask

  // One job from IDLE; optional start pulse in the middle of the job.
  task automatic test_job(input string name, input logic [WIDTH-1:0] din,
                          input logic dir, input int count, input logic glitch);
    int c, d0;
    logic [4:0] e, o;
    logic [WIDTH-1:0] ey;
    c = clamp(count);
    checks++;
    if (sif.ready !== 1'b1) begin
      failures++;
      $display("FAIL %s_ready_before: got %b expected 1", name, sif.ready);
    end
    sif.start = 1'b1; sif.din = din; sif.dir = dir; sif.count = CNT_W'(count);
    exp_q.push_back(final_word(din, dir, c));
    d0 = done_seen;
    step();
    sif.start = 1'b0;
    sif.din = WIDTH'($urandom); sif.dir = 1'($urandom); sif.count = CNT_W'($urandom);
    for (int j = 0; j <= c + 3; j++) begin
      if (j > 0) step();
      if (glitch && c >= 1 && j == 2) begin sif.start = 1'b1; sif.din = ~din; end
      if (glitch && c >= 1 && j == 3) sif.start = 1'b0;
      e = exp_sig(j, c, dir);
      o = {sif.mode, sif.busy, sif.done, sif.ready};
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL %s_sig_j%0d: got mode/busy/done/ready=%b expected %b", name, j, o, e);
      end
      checks++;
      if (sif.data !== din) begin
        failures++;
        $display("FAIL %s_data_j%0d: got %b expected %b", name, j, sif.data, din);
      end
      if (sif.done === 1'b1 && exp_q.size() > 0) begin
        ey = exp_q.pop_front();
        checks++;
        if (usr_y !== ey) begin
          failures++;
          $display("FAIL %s_usr_y: got %b expected %b", name, usr_y, ey);
        end
      end
    end
    checks++;
    if (done_seen - d0 !== 1) begin
      failures++;
      $display("FAIL %s_done_count: got %0d expected 1", name, done_seen - d0);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_scoreboard_left: got %0d expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_directed();
    test_job("right4", 4'b1011, 1'b0, 4, 1'b0);
    test_job("left2",  4'b1101, 1'b1, 2, 1'b0);
    test_job("count0", 4'b0110, 1'b0, 0, 1'b0);
  endtask

  task automatic test_clamp_ignore();
    test_job("clamp7", 4'b1111, 1'b1, 7, 1'b1);
  endtask

  task automatic test_reset_mid_job();
    int d0;
    sif.start = 1'b1; sif.din = 4'b1110; sif.dir = 1'b0; sif.count = 3'd4;
    d0 = done_seen;
    step();              // accept
    sif.start = 1'b0;
    step(); step(); step(); // load, 1st shift, 2nd shift visible
    checks++;
    if (sif.mode !== MODE_SHR) begin
      failures++;
      $display("FAIL rstmid_pre_mode: got %b expected %b", sif.mode, MODE_SHR);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({sif.mode, sif.busy, sif.done, sif.ready} !== 5'b00_0_0_1) begin
      failures++;
      $display("FAIL rstmid_outputs: got %b expected %b",
               {sif.mode, sif.busy, sif.done, sif.ready}, 5'b00_0_0_1);
    end
    checks++;
    if (sif.data !== 4'b0000) begin
      failures++;
      $display("FAIL rstmid_data: got %b expected 0000", sif.data);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if ({sif.mode, sif.busy, sif.done} !== 4'b00_0_0) begin
        failures++;
        $display("FAIL rstmid_quiet_%0d: got %b expected 0000", i, {sif.mode, sif.busy, sif.done});
      end
    end
    checks++;
    if (done_seen != d0) begin
      failures++;
      $display("FAIL rstmid_no_done: got %0d pulses expected 0", done_seen - d0);
    end
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] din_a, din_b, ey;
    int tb, d0, ca, cb;
    logic [4:0] e, o;
    din_a = 4'b1001; din_b = 4'b0011; ca = 1; cb = 1;
    tb = ca + 3;         // edge index (from A's accept) on which B is accepted
    exp_q.push_back(final_word(din_a, 1'b0, ca));
    exp_q.push_back(final_word(din_b, 1'b1, cb));
    d0 = done_seen;
    sif.start = 1'b1; sif.din = din_a; sif.dir = 1'b0; sif.count = CNT_W'(ca);
    step();
    for (int t = 0; t <= tb + cb + 3; t++) begin
      if (t > 0) step();
      if (t == tb - 1) begin sif.din = din_b; sif.dir = 1'b1; sif.count = CNT_W'(cb); end
      if (t == tb) sif.start = 1'b0;
      e = (t < tb) ? exp_sig(t, ca, 1'b0) : exp_sig(t - tb, cb, 1'b1);
      o = {sif.mode, sif.busy, sif.done, sif.ready};
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL b2b_sig_t%0d: got mode/busy/done/ready=%b expected %b", t, o, e);
      end
      checks++;
      if (sif.data !== ((t < tb) ? din_a : din_b)) begin
        failures++;
        $display("FAIL b2b_data_t%0d: got %b expected %b", t, sif.data, (t < tb) ? din_a : din_b);
      end
      if (sif.done === 1'b1 && exp_q.size() > 0) begin
        ey = exp_q.pop_front();
        checks++;
        if (usr_y !== ey) begin
          failures++;
          $display("FAIL b2b_usr_y_t%0d: got %b expected %b", t, usr_y, ey);
        end
      end
    end
    checks++;
    if (done_seen - d0 !== 2) begin
      failures++;
      $display("FAIL b2b_done_count: got %0d expected 2", done_seen - d0);
    end
    exp_q.delete();
  endtask

  task automatic test_random();
    for (int n = 0; n < 16; n++) begin
      test_job($sformatf("rand%0d", n), WIDTH'($urandom), 1'($urandom),
               $urandom_range(0, 7), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) step();
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_directed();
    test_clamp_ignore();
    test_reset_mid_job();
    test_back_to_back();
    step();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
